// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide controller: request types,
// MULDIV operation codes and the controller state enum.
package md_pkg;

    typedef enum logic [2:0] {
        REQ_MULT  = 3'd0,
        REQ_MULTU = 3'd1,
        REQ_DIV   = 3'd2,
        REQ_DIVU  = 3'd3,
        REQ_MTHI  = 3'd4,
        REQ_MTLO  = 3'd5,
        REQ_MFHI  = 3'd6,
        REQ_MFLO  = 3'd7
    } req_type_e;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

    // Arithmetic request codes map one-to-one onto the MULDIV op field.
    function automatic md_op_e to_md_op(input logic [2:0] req_type);
        return md_op_e'(req_type[1:0]);
    endfunction

endpackage

// File: rtl/md_ctrl.sv
// Execute-stage controller for the MULDIV unit: issues multiply/divide,
// HI/LO moves and reads, stalls the pipe while the unit is busy.
module md_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic [2:0]  req_type,
    input  logic        flush,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        stall,
    output logic        md_start,
    output logic [1:0]  md_op,
    output logic        md_we,
    output logic        md_hilo,
    output logic [31:0] md_d1,
    output logic [31:0] md_d2,
    input  logic        md_busy,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic [31:0] mf_data,
    output logic        mf_valid,
    output logic        err
);
    import md_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             err_next;
    logic             req_live;
    logic             accept;
    req_type_e        req_kind;

    assign req_kind = req_type_e'(req_type);

    // rst_n gates the request so no command or stall escapes while in reset.
    assign req_live = rst_n & req_valid & ~flush;
    assign stall    = req_live & (state != ST_IDLE);
    assign accept   = req_live & ~stall;

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no latch is inferred.
        state_next = state;
        cnt_next   = cnt;
        err_next   = err;
        md_start   = 1'b0;
        md_op      = 2'd0;
        md_we      = 1'b0;
        md_hilo    = 1'b0;
        md_d1      = '0;
        md_d2      = '0;
        mf_data    = '0;
        mf_valid   = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    unique case (req_kind)
                        REQ_MULT, REQ_MULTU, REQ_DIV, REQ_DIVU: begin
                            md_start   = 1'b1;
                            md_op      = to_md_op(req_type);
                            md_d1      = rs_val;
                            md_d2      = rt_val;
                            state_next = ST_START;
                        end
                        REQ_MTHI, REQ_MTLO: begin
                            md_we   = 1'b1;
                            md_hilo = (req_kind == REQ_MTHI);
                            md_d1   = rs_val;
                        end
                        REQ_MFHI: begin
                            mf_valid = 1'b1;
                            mf_data  = md_hi;
                        end
                        REQ_MFLO: begin
                            mf_valid = 1'b1;
                            mf_data  = md_lo;
                        end
                        default: ;
                    endcase
                end
            end
            // md_busy is not yet valid here; it rises one cycle after md_start.
            ST_START: begin
                state_next = ST_BUSY;
                cnt_next   = '0;
            end
            ST_BUSY: begin
                if (!md_busy) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= state_next;
            cnt   <= cnt_next;
            err   <= err_next;
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: decode table, multi-cycle corner
// sequences and a randomized run against a cycle-level reference model.
module tb_md_ctrl;
    import md_pkg::*;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [2:0]  req_type;
    logic        flush;
    logic [31:0] rs_val, rt_val;
    logic        stall, md_start, md_we, md_hilo, mf_valid, err;
    logic [1:0]  md_op;
    logic [31:0] md_d1, md_d2, mf_data;
    logic        md_busy;
    logic [31:0] md_hi, md_lo;

    always #5 clk = ~clk;

    md_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_type(req_type),
        .flush(flush), .rs_val(rs_val), .rt_val(rt_val), .stall(stall),
        .md_start(md_start), .md_op(md_op), .md_we(md_we), .md_hilo(md_hilo),
        .md_d1(md_d1), .md_d2(md_d2), .md_busy(md_busy), .md_hi(md_hi),
        .md_lo(md_lo), .mf_data(mf_data), .mf_valid(mf_valid), .err(err)
    );

    typedef struct packed {
        logic        stall;
        logic        md_start;
        logic [1:0]  md_op;
        logic        md_we;
        logic        md_hilo;
        logic [31:0] md_d1;
        logic [31:0] md_d2;
        logic        mf_valid;
        logic [31:0] mf_data;
    } outs_t;

    typedef struct {
        string       name;
        logic        rv;
        logic [2:0]  ty;
        logic        fl;
        logic [31:0] rs, rt, hi, lo;
        outs_t       exp;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, 128'(act), 128'(exp));
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, 128'(act), 128'(exp));
    endtask

    function automatic outs_t sample_outs();
        outs_t o;
        o.stall = stall;     o.md_start = md_start; o.md_op = md_op;
        o.md_we = md_we;     o.md_hilo = md_hilo;   o.md_d1 = md_d1;
        o.md_d2 = md_d2;     o.mf_valid = mf_valid; o.mf_data = mf_data;
        return o;
    endfunction

    function automatic outs_t mk(input logic st, input logic start, input logic [1:0] op,
                                 input logic we, input logic hilo, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic mfv, input logic [31:0] mfd);
        outs_t o;
        o.stall = st;   o.md_start = start; o.md_op = op;  o.md_we = we;
        o.md_hilo = hilo; o.md_d1 = d1;     o.md_d2 = d2;  o.mf_valid = mfv;
        o.mf_data = mfd;
        return o;
    endfunction

    task automatic drive(input logic rv, input logic [2:0] ty, input logic fl,
                         input logic [31:0] rs, input logic [31:0] rt);
        req_valid = rv; req_type = ty; flush = fl; rs_val = rs; rt_val = rt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Reference model: tracks whether an arithmetic op is in flight and how
    // many cycles have passed since it was issued.
    bit m_inflight;
    int m_age;
    bit m_err;

    function automatic outs_t ref_outs();
        outs_t o;
        logic  live;
        o = '0;
        live = req_valid && !flush;
        if (live && m_inflight) o.stall = 1'b1;
        if (live && !m_inflight) begin
            if (req_type < 3'd4) begin
                o.md_start = 1'b1; o.md_op = req_type[1:0];
                o.md_d1 = rs_val;  o.md_d2 = rt_val;
            end else if (req_type < 3'd6) begin
                o.md_we = 1'b1; o.md_hilo = (req_type == 3'd4); o.md_d1 = rs_val;
            end else begin
                o.mf_valid = 1'b1;
                o.mf_data  = (req_type == 3'd6) ? md_hi : md_lo;
            end
        end
        return o;
    endfunction

    task automatic model_step();
        if (!m_inflight) begin
            if (req_valid && !flush && req_type < 3'd4) begin
                m_inflight = 1'b1;
                m_age = 1;
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (!md_busy) begin
            m_inflight = 1'b0;
        end else if (m_age - 1 == TIMEOUT) begin
            m_err = 1'b1;
            m_inflight = 1'b0;
        end else begin
            m_age++;
        end
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{"mult",     1, 3'd0, 0, 32'h1234_5678, 32'h9abc_def0, 0, 0,
                    mk(0, 1, 2'd0, 0, 0, 32'h1234_5678, 32'h9abc_def0, 0, 0)};
        vecs[1] = '{"multu100", 1, 3'd1, 0, 32'd100, 32'd100, 0, 0,
                    mk(0, 1, 2'd1, 0, 0, 32'd100, 32'd100, 0, 0)};
        vecs[2] = '{"div",      1, 3'd2, 0, 32'd7, 32'd3, 0, 0,
                    mk(0, 1, 2'd2, 0, 0, 32'd7, 32'd3, 0, 0)};
        vecs[3] = '{"divu_by0", 1, 3'd3, 0, 32'd5, 32'd0, 0, 0,
                    mk(0, 1, 2'd3, 0, 0, 32'd5, 32'd0, 0, 0)};
        vecs[4] = '{"mthi",     1, 3'd4, 0, 32'hDEAD_BEEF, 32'h1111, 0, 0,
                    mk(0, 0, 2'd0, 1, 1, 32'hDEAD_BEEF, 0, 0, 0)};
        vecs[5] = '{"mtlo",     1, 3'd5, 0, 32'h55, 32'h66, 0, 0,
                    mk(0, 0, 2'd0, 1, 0, 32'h55, 0, 0, 0)};
        vecs[6] = '{"mfhi",     1, 3'd6, 0, 32'h1, 32'h2, 32'hAAAA_0001, 32'hBBBB_0002,
                    mk(0, 0, 2'd0, 0, 0, 0, 0, 1, 32'hAAAA_0001)};
        vecs[7] = '{"mflo",     1, 3'd7, 0, 32'h1, 32'h2, 32'hAAAA_0001, 32'hBBBB_0002,
                    mk(0, 0, 2'd0, 0, 0, 0, 0, 1, 32'hBBBB_0002)};
        vecs[8] = '{"div_flush", 1, 3'd2, 1, 32'd9, 32'd4, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[9] = '{"no_valid",  0, 3'd0, 0, 32'd9, 32'd4, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0)};

        // Reset held low with random inputs: everything quiet.
        rst_n = 1'b0;
        md_busy = 1'b0; md_hi = '0; md_lo = '0;
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(1'($urandom), 3'($urandom), 1'($urandom), $urandom, $urandom);
            md_busy = 1'($urandom); md_hi = $urandom; md_lo = $urandom;
            #3;
            check1("rst_stall", stall, 0);
            check1("rst_start", md_start, 0);
            check1("rst_we", md_we, 0);
            check1("rst_mfv", mf_valid, 0);
            check1("rst_err", err, 0);
            @(posedge clk);
        end
        #1;
        drive(0, 0, 0, 0, 0); md_busy = 1'b0;
        rst_n = 1'b1;

        // Combinational decode in IDLE; request drops before the edge.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i].rv, vecs[i].ty, vecs[i].fl, vecs[i].rs, vecs[i].rt);
            md_hi = vecs[i].hi; md_lo = vecs[i].lo;
            #1;
            check(vecs[i].name, 128'(sample_outs()), 128'(vecs[i].exp));
            req_valid = 1'b0;
        end
        tick();

        // MULTU 100*100 then MFLO held while the unit is busy.
        drive(1, 3'd1, 0, 32'd100, 32'd100); md_busy = 1'b0;
        settle();
        check("multu_issue", 128'(sample_outs()), 128'(mk(0, 1, 2'd1, 0, 0, 100, 100, 0, 0)));
        tick();
        drive(1, 3'd7, 0, 0, 0);
        settle();
        check1("mflo_start_stall", stall, 1);
        check1("mflo_start_nostart", md_start, 0);
        for (int i = 0; i < 5; i++) begin
            tick(); md_busy = 1'b1; settle();
            check1("mflo_busy_stall", stall, 1);
            check1("mflo_busy_mfv", mf_valid, 0);
        end
        tick(); md_busy = 1'b0; md_lo = 32'd10000; settle();
        check1("mflo_fall_stall", stall, 1);
        check1("mflo_fall_mfv", mf_valid, 0);
        tick(); settle();
        check1("mflo_idle_stall", stall, 0);
        check1("mflo_idle_mfv", mf_valid, 1);
        check32("mflo_idle_data", mf_data, 32'd10000);
        tick(); drive(0, 0, 0, 0, 0);

        // MULT then DIV back-to-back, with a flush pulse mid-operation.
        drive(1, 3'd0, 0, 32'd3, 32'd4); settle();
        check1("bb_mult_start", md_start, 1);
        tick(); drive(1, 3'd2, 0, 32'd10, 32'd2); md_busy = 1'b0; settle();
        check1("bb_start_stall", stall, 1);
        check1("bb_start_nostart", md_start, 0);
        tick(); md_busy = 1'b1; settle();
        check1("bb_busy_stall", stall, 1);
        tick(); flush = 1'b1; settle();
        check1("bb_flush_nostall", stall, 0);
        check1("bb_flush_nostart", md_start, 0);
        tick(); flush = 1'b0; settle();
        check1("bb_noabort_stall", stall, 1);
        tick(); md_busy = 1'b0; settle();
        check1("bb_fall_stall", stall, 1);
        check1("bb_fall_nostart", md_start, 0);
        tick(); settle();
        check("bb_div_issue", 128'(sample_outs()), 128'(mk(0, 1, 2'd2, 0, 0, 10, 2, 0, 0)));
        tick(); drive(0, 0, 0, 0, 0); md_busy = 1'b0;
        repeat (3) tick();

        // MTHI and a flushed DIV leave the FSM idle.
        drive(1, 3'd4, 0, 32'hDEAD_BEEF, 0); settle();
        check("mthi_issue", 128'(sample_outs()), 128'(mk(0, 0, 0, 1, 1, 32'hDEAD_BEEF, 0, 0, 0)));
        tick(); drive(1, 3'd2, 1, 32'd8, 32'd2); settle();
        check1("flush_div_nostart", md_start, 0);
        check1("flush_div_nostall", stall, 0);
        tick(); drive(1, 3'd6, 0, 0, 0); md_hi = 32'h1357; settle();
        check1("after_flush_mfv", mf_valid, 1);
        check32("after_flush_data", mf_data, 32'h1357);
        tick(); drive(0, 0, 0, 0, 0);

        // Timeout: md_busy stuck high after a MULT.
        drive(1, 3'd0, 0, 1, 1); settle();
        tick(); drive(0, 0, 0, 0, 0); md_busy = 1'b1;
        repeat (TIMEOUT) tick();
        drive(1, 3'd6, 0, 0, 0); settle();
        check1("to_last_busy_stall", stall, 1);
        check1("to_last_busy_err", err, 0);
        tick(); settle();
        check1("to_err_set", err, 1);
        check1("to_idle_stall", stall, 0);
        check1("to_idle_mfv", mf_valid, 1);
        drive(0, 0, 0, 0, 0);
        repeat (5) tick();
        drive(1, 3'd1, 0, 2, 2); tick(); drive(0, 0, 0, 0, 0); md_busy = 1'b0;
        repeat (3) tick();
        check1("to_err_sticky", err, 1);
        rst_n = 1'b0; settle();
        check1("to_err_clear", err, 0);
        rst_n = 1'b1;
        tick();

        // Reset during BUSY returns to IDLE and ignores md_busy.
        drive(1, 3'd0, 0, 5, 5); tick();
        drive(0, 0, 0, 0, 0); md_busy = 1'b1; tick(); tick();
        req_valid = 1'b1; req_type = 3'd6;
        rst_n = 1'b0; settle();
        check1("rst_busy_stall", stall, 0);
        rst_n = 1'b1; md_hi = 32'h2468; settle();
        check1("rst_busy_mfv", mf_valid, 1);
        check1("rst_busy_idle", stall, 0);
        check32("rst_busy_data", mf_data, 32'h2468);
        tick(); drive(0, 0, 0, 0, 0); md_busy = 1'b0;

        // Randomized run against the reference model.
        rst_n = 1'b0; settle(); rst_n = 1'b1;
        m_inflight = 1'b0; m_age = 0; m_err = 1'b0;
        tick();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom), ($urandom_range(0, 7) == 0),
                  $urandom, $urandom);
            md_busy = ($urandom_range(0, 4) != 0);
            md_hi = $urandom; md_lo = $urandom;
            settle();
            check("rand_outs", 128'(sample_outs()), 128'(ref_outs()));
            check1("rand_err", err, m_err);
            @(posedge clk);
            model_step();
            #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
